conv_out_ctrl: RTL and testbench
================================

// Module: conv_out_ctrl
// PURPOSE
//  Output-side counterpart of the image controller. Collects finished convolution results tagged
//  with output coordinates {row, col}, which may arrive in any order. Buffers one full O_DIM x O_DIM
//  frame, then streams it to the output DMA channel as an AXI stream in raster order, with LAST on
//  the final word. Sits between the multiplier/adder array and the S2MM DMA channel.
// PARAMETERS
//  K_DIM   3                   kernel dimension
//  I_DIM   8                   image cache dimension
//  M_BITS  16                  data width (floating-point bits, treated as opaque)
//  O_DIM   K_DIM+I_DIM-1       output dimension
//  O_SIZE  sq(O_DIM)           words per frame
//  O_BITS  nbits(O_DIM)        coordinate width
//  A_BITS  nbits(O_SIZE)       buffer address width
// PORTS
//  clk        in   1              clock
//  rst        in   1              synchronous reset, active-high
//  in_data    in   M_BITS         result word
//  in_user    in   [1:0][O_BITS]  {row, col} of in_data
//  in_last    in   1              final result of the frame
//  in_valid   in   1              result valid
//  in_ready   out  1              block accepts result
//  out_data   out  M_BITS         DMA stream data
//  out_last   out  1              final word of the frame (address O_SIZE-1)
//  out_valid  out  1              DMA stream valid
//  out_ready  in   1              DMA stream ready
//  err_range  out  1              sticky: a coordinate >= O_DIM was received
//  err_miss   out  1              sticky: a word was drained from an unwritten slot
// BEHAVIOUR
//  Reset: state=FILL, rd_addr=0, written bitmap cleared. Outputs: in_ready=1, out_valid=0,
//   out_last=0, out_data=0, err_range=0, err_miss=0. Reset mid-DRAIN abandons the frame.
//  FSM FILL:
//   - in_ready=1, out_valid=0.
//   - On in_valid&&in_ready: addr = row*O_DIM+col, computed at A_BITS width with no truncation.
//   - In-range beat: writes mem[addr] and sets written[addr] on the next edge.
//   - Duplicate coordinate: last write wins.
//   - Out-of-range beat (row or col >= O_DIM): no write; sets err_range; still counts for in_last.
//   - Handshake with in_last=1: the beat is written/processed as above, then FILL->DRAIN, rd_addr=0.
//  FSM DRAIN:
//   - in_ready=0, out_valid=1.
//   - out_data = written[rd_addr] ? mem[rd_addr] : '0, combinational from registered rd_addr.
//   - out_last = (rd_addr == O_SIZE-1).
//   - On out_valid&&out_ready: rd_addr+1. Driving an unwritten slot sets err_miss at that handshake.
//   - out_data/out_last are held stable while out_ready=0.
//   - Handshake with out_last: DRAIN->FILL, written cleared, rd_addr=0. in_ready=1 the next cycle.
//  Latency: first output word is valid in the cycle after the in_last handshake.
//   Full drain is O_SIZE handshakes. Throughput is 1 word/cycle each direction.
//  No simultaneous in/out: in_ready and out_valid are mutually exclusive by state.
//  Errors clear only on rst.
//  Frame with in_last but zero in-range beats: drains O_SIZE zeros, err_miss=1.
// STRUCTURE
//  Shared package conv_pkg:
//   - typedef enum logic [0:0] {FILL, DRAIN} out_state_t
//   - sq()/nbits() helpers, O_DIM/O_SIZE derivations shared with the image controller.
//  Sub-module out_frame_buf: O_SIZE x M_BITS flop array plus written bitmap;
//   sync write, async read, single-cycle bulk clear.
//  Top holds the FSM, address math, read counter and error flags.
// TESTING  (defaults: O_DIM=10, O_SIZE=100)
//  1. 100 beats in raster order, data=addr, last on (9,9)
//     -> 100 out words 0..99, out_last only on word 99, err_*=0.
//  2. Same 100 beats in reverse order, last on (0,0)
//     -> output still 0..99 raster order, err_*=0.
//  3. 100 beats; out_ready toggles 1-of-3 cycles during drain
//     -> no dropped/duplicated word, data stable while stalled.
//  4. Beats omitting (4,7), plus one beat at (10,2)
//     -> word 47 = 0, err_miss=1, err_range=1, others intact.
//  5. (3,3) written twice (0xAAAA then 0x5555) -> word 33 = 0x5555.
//  6. rst asserted at drain word 50, then a new full frame
//     -> next cycle out_valid=0, in_ready=1; next frame drains cleanly from word 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared parameters, types and helpers for the convolution
// image/output controllers.
package conv_pkg;

  function automatic int sq(int n);
    return n * n;
  endfunction

  function automatic int nbits(int n);
    return $clog2(n + 1);
  endfunction

  localparam int K_DIM  = 3;
  localparam int I_DIM  = 8;
  localparam int M_BITS = 16;
  localparam int O_DIM  = K_DIM + I_DIM - 1;
  localparam int O_SIZE = sq(O_DIM);
  localparam int O_BITS = nbits(O_DIM);
  localparam int A_BITS = nbits(O_SIZE);

  typedef enum logic [0:0] {FILL, DRAIN} out_state_t;

  typedef logic [A_BITS-1:0] addr_t;
  typedef logic [M_BITS-1:0] word_t;
  typedef logic [O_BITS-1:0] coord_t;

endpackage

// File: rtl/conv_out_ctrl_if.sv
// Result input stream and DMA output stream of the
// output controller.
interface conv_out_ctrl_if;
  import conv_pkg::*;

  word_t                   in_data;
  logic [1:0][O_BITS-1:0]  in_user;
  logic                    in_last;
  logic                    in_valid;
  logic                    in_ready;

  word_t                   out_data;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_user, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_user, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );

endinterface

// File: rtl/conv_out_ctrl_frame_buf.sv
// One-frame result buffer: flop array with a written bitmap,
// sync write, async read, single-cycle bulk clear.
module out_frame_buf
  import conv_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t waddr,
  input  word_t wdata,
  input  logic  clr,
  input  addr_t raddr,
  output word_t rdata,
  output logic  rvalid
);

  word_t             mem [O_SIZE];
  logic [O_SIZE-1:0] written;

  // Data array: no reset, slots are qualified by the bitmap.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Written bitmap: cleared on reset or at end of drain.
  always_ff @(posedge clk) begin
    if (rst || clr) written <= '0;
    else if (we)    written[waddr] <= 1'b1;
  end

  assign rdata  = mem[raddr];
  assign rvalid = written[raddr];

endmodule

// File: rtl/conv_out_ctrl.sv
// Output controller: gathers out-of-order results into a
// frame buffer, then streams the frame in raster order.
module conv_out_ctrl
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  conv_out_ctrl_if.slave  bus,
  output logic            err_range,
  output logic            err_miss
);

  out_state_t state_q, state_d;
  addr_t      rd_addr_q, rd_addr_d;

  coord_t row, col;
  logic   in_range;
  addr_t  wr_addr;
  logic   we, clr;
  word_t  rdata;
  logic   rvalid;
  logic   is_last;

  logic   in_ready, out_valid, out_last;
  word_t  out_data;

  assign row      = bus.in_user[1];
  assign col      = bus.in_user[0];
  assign in_range = (row < coord_t'(O_DIM)) &&
                    (col < coord_t'(O_DIM));
  assign wr_addr  = addr_t'(row) * addr_t'(O_DIM)
                  + addr_t'(col);
  assign we       = bus.in_valid && in_ready && in_range;
  assign is_last  = (rd_addr_q == addr_t'(O_SIZE - 1));

  out_frame_buf u_buf (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (wr_addr),
    .wdata  (bus.in_data),
    .clr    (clr),
    .raddr  (rd_addr_q),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  // FSM state and read pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Next state, read pointer and stream outputs.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    clr       = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) begin
          state_d   = DRAIN;
          rd_addr_d = '0;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = is_last;
        out_data  = rvalid ? rdata : '0;
        if (bus.out_ready) begin
          if (is_last) begin
            state_d   = FILL;
            rd_addr_d = '0;
            clr       = 1'b1;
          end else begin
            rd_addr_d = rd_addr_q + addr_t'(1);
          end
        end
      end
    endcase
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_range <= 1'b0;
      err_miss  <= 1'b0;
    end else begin
      if (bus.in_valid && in_ready && !in_range)
        err_range <= 1'b1;
      if (out_valid && bus.out_ready && !rvalid)
        err_miss <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = out_data;

endmodule

// File: tb/tb_conv_out_ctrl.sv
// Directed bench for conv_out_ctrl: table of frame scenarios
// plus a hand-written mid-drain reset sequence.
module tb_conv_out_ctrl;
  import conv_pkg::*;

  typedef struct {
    string       name;
    bit          reverse;
    bit          stall;
    bit          omit47;
    bit          bad_beat;
    bit          dup33;
    bit          exp_range;
    bit          exp_miss;
    int          spot_addr;
    logic [15:0] spot_exp;
  } vec_t;

  typedef struct {
    int          r;
    int          c;
    logic [15:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_range, err_miss;

  conv_out_ctrl_if ifc ();

  conv_out_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .err_range (err_range),
    .err_miss  (err_miss)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_mem [100];
  bit          exp_wr  [100];
  logic [15:0] got     [100];
  beat_t       q [$];
  vec_t        vecs [5];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.in_data   = '0;
    ifc.in_user   = '0;
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      exp_mem[i] = '0;
      exp_wr[i]  = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},  ifc.in_ready,  1);
    check({tag, ".out_valid"}, ifc.out_valid, 0);
    check({tag, ".out_last"},  ifc.out_last,  0);
    check({tag, ".out_data"},  ifc.out_data,  0);
  endtask

  task automatic send_beat(input int r, input int c,
                           input logic [15:0] d,
                           input bit last);
    ifc.in_valid   = 1'b1;
    ifc.in_user[1] = O_BITS'(r);
    ifc.in_user[0] = O_BITS'(c);
    ifc.in_data    = d;
    ifc.in_last    = last;
    if (r < 10 && c < 10) begin
      exp_mem[r*10+c] = d;
      exp_wr[r*10+c]  = 1'b1;
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic send_queue();
    for (int i = 0; i < q.size(); i++)
      send_beat(q[i].r, q[i].c, q[i].d, i == q.size() - 1);
  endtask

  task automatic build_raster(input logic [15:0] xor_mask);
    q.delete();
    for (int a = 0; a < 100; a++)
      q.push_back('{a / 10, a % 10, 16'(a) ^ xor_mask});
  endtask

  task automatic drain(input bit stall, input int nwords,
                       input string tag);
    int idx = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [15:0] prev_d = '0;
    logic prev_l = 1'b0;
    logic [15:0] e;
    while (idx < nwords && cyc < 1000) begin
      ifc.out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk);
      check({tag, ".valid"}, ifc.out_valid, 1);
      if (prev_stall) begin
        check({tag, ".hold_data"}, ifc.out_data, prev_d);
        check({tag, ".hold_last"}, ifc.out_last, prev_l);
      end
      if (ifc.out_ready) begin
        e = exp_wr[idx] ? exp_mem[idx] : 16'h0;
        check({tag, ".word"}, {ifc.out_last, ifc.out_data},
              {(idx == 99), e});
        got[idx] = ifc.out_data;
        idx++;
      end
      prev_stall = !ifc.out_ready;
      prev_d     = ifc.out_data;
      prev_l     = ifc.out_last;
      @(posedge clk);
      #1;
      cyc++;
    end
    ifc.out_ready = 1'b0;
    if (idx < nwords) begin
      errors++;
      $display("FAIL %s.timeout: got %0d words expected %0d",
               tag, idx, nwords);
    end
  endtask

  initial begin
    vecs[0] = '{"raster",  0, 0, 0, 0, 0, 0, 0, 57, 16'd57};
    vecs[1] = '{"reverse", 1, 0, 0, 0, 0, 0, 0, 12, 16'd12};
    vecs[2] = '{"stall",   0, 1, 0, 0, 0, 0, 0, 99, 16'd99};
    vecs[3] = '{"hole",    0, 0, 1, 1, 0, 1, 1, 47, 16'h0};
    vecs[4] = '{"dup",     0, 0, 0, 0, 1, 0, 0, 33, 16'h5555};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      check_idle({vecs[v].name, ".rst"});
      check({vecs[v].name, ".rst.err_range"}, err_range, 0);
      check({vecs[v].name, ".rst.err_miss"},  err_miss,  0);

      q.delete();
      for (int k = 0; k < 100; k++) begin
        int a;
        logic [15:0] d;
        a = vecs[v].reverse ? 99 - k : k;
        if (vecs[v].omit47 && a == 47) continue;
        d = (vecs[v].dup33 && a == 33) ? 16'h5555 : 16'(a);
        q.push_back('{a / 10, a % 10, d});
      end
      if (vecs[v].dup33)
        q.push_front('{3, 3, 16'hAAAA});
      if (vecs[v].bad_beat)
        q.insert(50, '{10, 2, 16'hDEAD});
      send_queue();

      check({vecs[v].name, ".lat.out_valid"}, ifc.out_valid, 1);
      check({vecs[v].name, ".lat.in_ready"},  ifc.in_ready,  0);

      drain(vecs[v].stall, 100, vecs[v].name);

      check({vecs[v].name, ".post.out_valid"}, ifc.out_valid, 0);
      check({vecs[v].name, ".post.in_ready"},  ifc.in_ready,  1);
      check({vecs[v].name, ".err_range"}, err_range,
            vecs[v].exp_range);
      check({vecs[v].name, ".err_miss"},  err_miss,
            vecs[v].exp_miss);
      check({vecs[v].name, ".spot"}, got[vecs[v].spot_addr],
            vecs[v].spot_exp);
    end

    do_reset();
    build_raster(16'h0);
    send_queue();
    drain(1'b0, 50, "rst_mid");
    check("rst_mid.word50", ifc.out_data, 16'd50);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_idle("rst_mid.after");
    for (int i = 0; i < 100; i++) begin
      exp_mem[i] = '0;
      exp_wr[i]  = 1'b0;
    end
    build_raster(16'h00F0);
    send_queue();
    check("rst_mid.lat", ifc.out_valid, 1);
    drain(1'b0, 100, "rst_new");
    check("rst_new.in_ready",  ifc.in_ready, 1);
    check("rst_new.err_range", err_range, 0);
    check("rst_new.err_miss",  err_miss,  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
